axi_lite_led_slave: RTL

- AXI4-Lite responder behind the LED IP's S00_AXI port, answering the master VIP's single-beat writes and reads.
- Holds four 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Drives an LED output bus from the register contents, with an optional per-bit blink generator.
- Sits between the PS/VIP master and the board LED pins.

---
 rtl/axi_lite_led_pkg.sv | 13 +
 rtl/led_blink_gen.sv | 39 +++
 rtl/axi_lite_led_slave.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_led_pkg.sv
// Shared register-map offsets, response code and FSM state types for the
// AXI4-Lite LED responder.
package axi_lite_led_pkg;
   localparam logic [1:0] ADDR_LED_VAL    = 2'd0;
   localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
   localparam logic [1:0] ADDR_BLINK_DIV  = 2'd2;
   localparam logic [1:0] ADDR_SCRATCH    = 2'd3;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/led_blink_gen.sv
// Blink phase generator and registered LED mux: a counter runs 0..i_div and
// toggles the phase at terminal count; a zero divider parks the phase low.
module led_blink_gen #(
   parameter int NUM_LEDS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NUM_LEDS-1:0] i_led_val,
   input  logic [NUM_LEDS-1:0] i_mask,
   input  logic [31:0]         i_div,
   input  logic                i_div_wr,
   output logic [NUM_LEDS-1:0] o_led
);
   logic [31:0]         r_cnt;
   logic                r_phase;
   logic [NUM_LEDS-1:0] r_led;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_led   <= '0;
      end else begin
         // >= rather than == so lowering the divider below the count still wraps
         if (i_div_wr || (i_div == 32'd0)) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
         end else if (r_cnt >= i_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + 32'd1;
         end
         r_led <= i_led_val ^ (i_mask & {NUM_LEDS{r_phase}});
      end
   end

   assign o_led = r_led;
endmodule

// File: rtl/axi_lite_led_slave.sv
// AXI4-Lite responder with four 32-bit registers driving an LED bus.
// Define IP_AXI_LEDS_BLINK_EN to add the per-bit blink generator.
module axi_lite_led_slave
   import axi_lite_led_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_LEDS           = 8
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [NUM_LEDS-1:0]             led
);
   wr_state_t r_wr_state, w_wr_next;
   rd_state_t r_rd_state, w_rd_next;

   logic [31:0] r_regs [0:3];
   logic [1:0]  r_awaddr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
   logic [31:0] r_rdata;

   logic        w_aw_hs, w_w_hs, w_ar_hs;
   logic        w_do_wr;
   logic [1:0]  w_wr_addr;
   logic [31:0] w_wr_data;
   logic [3:0]  w_wr_strb;
   logic        w_unused_ok;

   // Handshakes use the registered readies, which stay low through reset
   assign w_aw_hs = s00_axi_awvalid && r_awready;
   assign w_w_hs  = s00_axi_wvalid  && r_wready;
   assign w_ar_hs = s00_axi_arvalid && r_arready;

   always_comb begin
      w_wr_next = r_wr_state;
      w_do_wr   = 1'b0;
      w_wr_addr = r_awaddr;
      w_wr_data = r_wdata;
      w_wr_strb = r_wstrb;
      case (r_wr_state)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_wr_next = W_RESP;
               w_do_wr   = 1'b1;
               w_wr_addr = s00_axi_awaddr[3:2];
               w_wr_data = s00_axi_wdata;
               w_wr_strb = s00_axi_wstrb;
            end else if (w_aw_hs) begin
               w_wr_next = W_HAVE_AW;
            end else if (w_w_hs) begin
               w_wr_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            if (w_w_hs) begin
               w_wr_next = W_RESP;
               w_do_wr   = 1'b1;
               w_wr_data = s00_axi_wdata;
               w_wr_strb = s00_axi_wstrb;
            end
         end
         W_HAVE_W: begin
            if (w_aw_hs) begin
               w_wr_next = W_RESP;
               w_do_wr   = 1'b1;
               w_wr_addr = s00_axi_awaddr[3:2];
            end
         end
         W_RESP: if (s00_axi_bready) w_wr_next = W_IDLE;
         default: w_wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_ar_hs) w_rd_next = R_DATA;
         R_DATA:  if (s00_axi_rready) w_rd_next = R_IDLE;
         default: w_rd_next = R_IDLE;
      endcase
   end

   // Channel outputs are decoded from the next state so they are registered
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_rdata    <= '0;
      end else begin
         r_wr_state <= w_wr_next;
         r_rd_state <= w_rd_next;
         r_awready  <= (w_wr_next == W_IDLE) || (w_wr_next == W_HAVE_W);
         r_wready   <= (w_wr_next == W_IDLE) || (w_wr_next == W_HAVE_AW);
         r_bvalid   <= (w_wr_next == W_RESP);
         r_arready  <= (w_rd_next == R_IDLE);
         r_rvalid   <= (w_rd_next == R_DATA);
         if (w_aw_hs) r_awaddr <= s00_axi_awaddr[3:2];
         if (w_w_hs) begin
            r_wdata <= s00_axi_wdata;
            r_wstrb <= s00_axi_wstrb;
         end
         if (w_ar_hs) r_rdata <= r_regs[s00_axi_araddr[3:2]];
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else if (w_do_wr) begin
         for (int b = 0; b < 4; b++)
            if (w_wr_strb[b]) r_regs[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
   end

`ifdef IP_AXI_LEDS_BLINK_EN
   logic                w_div_wr;
   logic [NUM_LEDS-1:0] w_led;

   assign w_div_wr = w_do_wr && (w_wr_addr == ADDR_BLINK_DIV);

   led_blink_gen #(.NUM_LEDS(NUM_LEDS)) u_blink (
      .i_clk     (s00_axi_aclk),
      .i_rst_n   (s00_axi_aresetn),
      .i_led_val (r_regs[ADDR_LED_VAL][NUM_LEDS-1:0]),
      .i_mask    (r_regs[ADDR_BLINK_MASK][NUM_LEDS-1:0]),
      .i_div     (r_regs[ADDR_BLINK_DIV]),
      .i_div_wr  (w_div_wr),
      .o_led     (w_led)
   );
   assign led = w_led;
`else
   logic [NUM_LEDS-1:0] r_led;

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) r_led <= '0;
      else                  r_led <= r_regs[ADDR_LED_VAL][NUM_LEDS-1:0];
   end
   assign led = r_led;
`endif

   // Protection bits and the byte-offset address bits carry no meaning here
   assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_wready;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_bresp   = RESP_OKAY;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rvalid  = r_rvalid;
   assign s00_axi_rdata   = r_rdata;
   assign s00_axi_rresp   = RESP_OKAY;
endmodule
